seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/adder.sv | 21 ++
 rtl/shift_add_mul.sv | 68 ++++++
 rtl/seq_alu.sv | 161 ++++++++++++++++
 tb/tb_seq_alu.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the registered ALU.
package alu_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SHLA = 3'b010;
   localparam logic [2:0] OP_SHLB = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_AND  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/adder.sv
// Plain N-bit ripple adder with carry in and carry out.
module adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   end

   assign sum  = full[N-1:0];
   assign cout = full[N];

endmodule

// File: rtl/shift_add_mul.sv
// N-cycle unsigned shift-add multiplier; done flags the cycle whose next product is final.
module shift_add_mul #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic           busy_q,  busy_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [2*N-1:0] acc_q,   acc_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [N:0]     hi_sum;
   logic [2*N-1:0] acc_step;

   // The multiplier sits in the low half and drains out as the product fills in from the top.
   always_comb begin
      hi_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
      acc_step = {hi_sum, acc_q[N-1:1]};
   end

   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      if (start) begin
         busy_d  = 1'b1;
         cnt_d   = '0;
         acc_d   = {{N{1'b0}}, b};
         mcand_d = a;
      end else if (busy_q) begin
         acc_d = acc_step;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == LAST);
   assign product = acc_step;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops finish at the accept edge, MUL finishes N edges later.
// start/ready: a request is taken on a rising edge with start=1 and ready=1; otherwise it is dropped.
module seq_alu
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         cf,
   output logic         ovf,
   output logic         zf
);

   state_t         state_q, state_d;
   logic [N-1:0]   result_q, result_d;
   logic [N-1:0]   result_hi_q, result_hi_d;
   logic           cf_q, cf_d;
   logic           ovf_q, ovf_d;
   logic           zf_q, zf_d;
   logic           done_q, done_d;

   logic [N-1:0]   add_sum;
   logic           add_cout;
   logic [N:0]     sub_full;
   logic [N-1:0]   sub_res;
   logic           mul_start;
   logic           mul_busy;
   logic           mul_done;
   logic [2*N-1:0] mul_product;

   adder #(.N(N)) u_adder (
      .a    (a),
      .b    (b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   shift_add_mul #(.N(N)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Carry out of a + ~b + 1 is the inverse of the borrow.
   always_comb begin
      sub_full = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
      sub_res  = sub_full[N-1:0];
   end

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      cf_d        = cf_q;
      ovf_d       = ovf_q;
      zf_d        = zf_q;
      done_d      = 1'b0;
      mul_start   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d      = 1'b1;
               result_hi_d = '0;
               cf_d        = 1'b0;
               ovf_d       = 1'b0;
               case (op)
                  OP_NOP: result_hi_d = result_hi_q;
                  OP_ADD: begin
                     result_d = add_sum;
                     cf_d     = add_cout;
                     ovf_d    = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
                  end
                  OP_SHLA: begin
                     result_d = {a[N-2:0], 1'b0};
                     cf_d     = a[N-1];
                  end
                  OP_SHLB: begin
                     result_d = {b[N-2:0], 1'b0};
                     cf_d     = b[N-1];
                  end
                  OP_SUB: begin
                     result_d = sub_res;
                     cf_d     = ~sub_full[N];
                     ovf_d    = (a[N-1] != b[N-1]) && (sub_res[N-1] != a[N-1]);
                  end
                  OP_MUL: begin
                     done_d      = 1'b0;
                     result_hi_d = result_hi_q;
                     cf_d        = cf_q;
                     ovf_d       = ovf_q;
                     mul_start   = 1'b1;
                     state_d     = S_MUL_BUSY;
                  end
                  OP_AND: result_d = a & b;
                  OP_OR:  result_d = a | b;
                  default: ;
               endcase
               if (done_d) begin
                  zf_d = (result_d == '0);
               end
            end
         end
         S_MUL_BUSY: begin
            if (mul_done) begin
               result_d    = mul_product[N-1:0];
               result_hi_d = mul_product[2*N-1:N];
               cf_d        = |mul_product[2*N-1:N];
               ovf_d       = |mul_product[2*N-1:N];
               zf_d        = (mul_product[N-1:0] == '0);
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         cf_q        <= 1'b0;
         ovf_q       <= 1'b0;
         zf_q        <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         cf_q        <= cf_d;
         ovf_q       <= ovf_d;
         zf_q        <= zf_d;
         done_q      <= done_d;
      end
   end

   assign ready     = (state_q == S_IDLE) && !mul_busy;
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign cf        = cf_q;
   assign ovf       = ovf_q;
   assign zf        = zf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=8): vector table plus back-to-back, busy-ignore and reset-abort sequences.
module tb_seq_alu;

   localparam int N = 8;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] ADD  = 3'b001;
   localparam logic [2:0] SHLA = 3'b010;
   localparam logic [2:0] SHLB = 3'b011;
   localparam logic [2:0] SUB  = 3'b100;
   localparam logic [2:0] MUL  = 3'b101;
   localparam logic [2:0] AND_ = 3'b110;
   localparam logic [2:0] OR_  = 3'b111;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ready;
   logic         done;
   logic [N-1:0] result;
   logic [N-1:0] result_hi;
   logic         cf;
   logic         ovf;
   logic         zf;

   int tests_run = 0;
   int fails     = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [7:0] hi;
      logic       cf;
      logic       ovf;
      logic       zf;
      int         lat;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs[NV];

   seq_alu #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .ready     (ready),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .cf        (cf),
      .ovf       (ovf),
      .zf        (zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] r, input logic [7:0] h,
                               input logic c, input logic v, input logic z, input int l);
      vec_t t;
      t.op = o; t.a = x; t.b = y; t.res = r; t.hi = h;
      t.cf = c; t.ovf = v; t.zf = z; t.lat = l;
      return t;
   endfunction

   // lat = clock edges from the accept edge (inclusive) until done is visible; 0 means timeout.
   task automatic issue_and_wait(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      lat = 0;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  16'(ready),     16'h1);
      check({tag, "_done"},   16'(done),      16'h0);
      check({tag, "_result"}, 16'(result),    16'h0);
      check({tag, "_hi"},     16'(result_hi), 16'h0);
      check({tag, "_cf"},     16'(cf),        16'h0);
      check({tag, "_ovf"},    16'(ovf),       16'h0);
      check({tag, "_zf"},     16'(zf),        16'h1);
   endtask

   initial begin
      int lat;
      int ready_low;
      int done_at;

      vecs[0]  = mk(ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1);
      vecs[1]  = mk(ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
      vecs[2]  = mk(SUB,  8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1);
      vecs[3]  = mk(SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1);
      vecs[4]  = mk(SHLA, 8'h81, 8'h55, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1);
      vecs[5]  = mk(SHLB, 8'h33, 8'h40, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1);
      vecs[6]  = mk(AND_, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);
      vecs[7]  = mk(OR_,  8'hF0, 8'h0C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1);
      vecs[8]  = mk(MUL,  8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, N + 1);
      vecs[9]  = mk(MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b1, 1'b0, N + 1);
      vecs[10] = mk(ADD,  8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1);
      vecs[11] = mk(MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b1, 1'b0, N + 1);
      vecs[12] = mk(NOP,  8'hAA, 8'h55, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1);
      vecs[13] = mk(AND_, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1);
      vecs[14] = mk(NOP,  8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1);
      vecs[15] = mk(SUB,  8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1);
      vecs[16] = mk(MUL,  8'h00, 8'hAB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, N + 1);

      rst_n = 1'b0; start = 1'b0; op = NOP; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_reset");

      for (int i = 0; i < NV; i++) begin
         issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_lat", i),    16'(lat),       16'(vecs[i].lat));
         check($sformatf("v%0d_result", i), 16'(result),    16'(vecs[i].res));
         check($sformatf("v%0d_hi", i),     16'(result_hi), 16'(vecs[i].hi));
         check($sformatf("v%0d_cf", i),     16'(cf),        16'(vecs[i].cf));
         check($sformatf("v%0d_ovf", i),    16'(ovf),       16'(vecs[i].ovf));
         check($sformatf("v%0d_zf", i),     16'(zf),        16'(vecs[i].zf));
      end

      // Back-to-back ADDs: start held across two edges.
      @(negedge clk);
      start = 1'b1; op = ADD; a = 8'h7F; b = 8'h01;
      @(negedge clk);
      check("b2b_done0",   16'(done),   16'h1);
      check("b2b_result0", 16'(result), 16'h80);
      a = 8'hFF; b = 8'h01;
      @(negedge clk);
      check("b2b_done1",   16'(done),   16'h1);
      check("b2b_result1", 16'(result), 16'h00);
      check("b2b_cf1",     16'(cf),     16'h1);
      start = 1'b0;
      @(negedge clk);
      check("b2b_done2",   16'(done),   16'h0);
      check("b2b_hold",    16'(result), 16'h00);

      // MUL with an ADD request held on start while busy: the ADD must be dropped.
      @(negedge clk);
      start = 1'b1; op = MUL; a = 8'h0F; b = 8'h11;
      @(posedge clk);
      ready_low = 0;
      done_at   = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            op = ADD; a = 8'h01; b = 8'h01;
         end
         if (c == 5) start = 1'b0;
         if (done) begin
            done_at = c;
            break;
         end
         if (!ready) ready_low++;
      end
      check("busy_done_edge", 16'(done_at),   16'(N + 1));
      check("busy_ready_low", 16'(ready_low), 16'(N));
      check("busy_ready_end", 16'(ready),     16'h1);
      check("busy_result",    16'(result),    16'hFF);
      check("busy_hi",        16'(result_hi), 16'h00);
      @(negedge clk);
      check("busy_no_queue",  16'(done),      16'h0);

      // Async reset asserted between edges, mid-MUL.
      issue_and_wait(ADD, 8'h7F, 8'h01, lat);
      check("pre_abort_result", 16'(result), 16'h80);
      @(negedge clk);
      start = 1'b1; op = MUL; a = 8'hFF; b = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("abort_now");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("abort_low_done%0d", c), 16'(done), 16'h0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < N + 2; c++) begin
         @(negedge clk);
         check($sformatf("abort_rel_done%0d", c), 16'(done),   16'h0);
         check($sformatf("abort_rel_res%0d", c),  16'(result), 16'h0);
      end
      issue_and_wait(MUL, 8'h02, 8'h03, lat);
      check("fresh_mul_lat",    16'(lat),       16'(N + 1));
      check("fresh_mul_result", 16'(result),    16'h06);
      check("fresh_mul_hi",     16'(result_hi), 16'h00);
      check("fresh_mul_cf",     16'(cf),        16'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
